// File: rtl/branch_feedback_queue.sv
// Branch feedback queue: buffers resolved branches from EX toward the
// predictor update port and keeps branch/mispredict/drop statistics.
module branch_feedback_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_res_valid,
  input  logic [ADDR_WIDTH-1:0]        i_res_pc,
  input  logic                         i_res_prediction,
  input  logic                         i_res_outcome,
  output logic                         o_fb_valid,
  output logic [ADDR_WIDTH-1:0]        o_fb_pc,
  output logic                         o_fb_prediction,
  output logic                         o_fb_outcome,
  input  logic                         i_fb_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
  output logic                         o_full,
  output logic [CNT_WIDTH-1:0]         o_branch_cnt,
  output logic [CNT_WIDTH-1:0]         o_mispred_cnt,
  output logic [15:0]                  o_drop_cnt
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
    logic                  outc;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  entry_t                 head;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   full_q, full_d;
  logic [CNT_WIDTH-1:0]   branch_q, branch_d;
  logic [CNT_WIDTH-1:0]   mispred_q, mispred_d;
  logic [15:0]            drop_q, drop_d;
  logic                   not_empty;
  logic                   push;
  logic                   pop;

  assign not_empty = (occ_q != '0);
  assign pop       = not_empty & i_fb_ready;
  assign push      = i_res_valid & (~full_q | pop);

  // Next-state for pointers, occupancy and statistics counters
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    branch_d  = branch_q;
    mispred_d = mispred_q;
    drop_d    = drop_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end
    if (i_res_valid) begin
      branch_d = branch_q + 1'b1;
      if (i_res_prediction != i_res_outcome) begin
        mispred_d = mispred_q + 1'b1;
      end
      if (!push && drop_q != 16'hFFFF) begin
        drop_d = drop_q + 1'b1;
      end
    end
    full_d = (occ_d == OCC_W'(DEPTH));
  end

  // Control and counter state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      full_q    <= 1'b0;
      branch_q  <= '0;
      mispred_q <= '0;
      drop_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      full_q    <= full_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
      drop_q    <= drop_d;
    end
  end

  // Entry storage; contents are don't-care while not valid
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: i_res_pc, pred: i_res_prediction,
                           outc: i_res_outcome};
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign o_fb_valid      = not_empty;
  assign o_fb_pc         = not_empty ? head.pc : '0;
  assign o_fb_prediction = not_empty & head.pred;
  assign o_fb_outcome    = not_empty & head.outc;
  assign o_occupancy     = occ_q;
  assign o_full          = full_q;
  assign o_branch_cnt    = branch_q;
  assign o_mispred_cnt   = mispred_q;
  assign o_drop_cnt      = drop_q;

endmodule

// File: tb/tb_branch_feedback_queue.sv
// Directed bench for branch_feedback_queue: a DEPTH=4 instance for
// backpressure/reset/saturation and a DEPTH=3 instance for wrap-around.
module tb_branch_feedback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid, res_pred, res_out, fb_ready;
  logic [31:0] res_pc;
  logic        fb_valid, fb_pred, fb_out, full;
  logic [31:0] fb_pc, branch_cnt, mispred_cnt;
  logic [2:0]  occ;
  logic [15:0] drop_cnt;

  logic        v3, p3, o3, r3;
  logic [31:0] pc3;
  logic        fv3, fp3, fo3, full3;
  logic [31:0] fpc3, bc3, mc3;
  logic [1:0]  occ3;
  logic [15:0] dc3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_feedback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_res_valid(res_valid), .i_res_pc(res_pc),
    .i_res_prediction(res_pred), .i_res_outcome(res_out),
    .o_fb_valid(fb_valid), .o_fb_pc(fb_pc),
    .o_fb_prediction(fb_pred), .o_fb_outcome(fb_out),
    .i_fb_ready(fb_ready), .o_occupancy(occ), .o_full(full),
    .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt),
    .o_drop_cnt(drop_cnt)
  );

  branch_feedback_queue #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_res_valid(v3), .i_res_pc(pc3),
    .i_res_prediction(p3), .i_res_outcome(o3),
    .o_fb_valid(fv3), .o_fb_pc(fpc3),
    .o_fb_prediction(fp3), .o_fb_outcome(fo3),
    .i_fb_ready(r3), .o_occupancy(occ3), .o_full(full3),
    .o_branch_cnt(bc3), .o_mispred_cnt(mc3),
    .o_drop_cnt(dc3)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic p, input logic o);
    res_valid = 1'b1;
    res_pc    = pc;
    res_pred  = p;
    res_out   = o;
    tick();
    res_valid = 1'b0;
  endtask

  logic [31:0] exp_pc [4];
  int          rcv;
  int          exp_mis;

  initial begin
    rst = 1'b1;
    res_valid = 0; res_pc = 0; res_pred = 0; res_out = 0; fb_ready = 0;
    v3 = 0; pc3 = 0; p3 = 0; o3 = 0; r3 = 0;
    #12;
    chk("rst_valid", fb_valid, 0);
    chk("rst_pc", fb_pc, 0);
    chk("rst_occ", occ, 0);
    chk("rst_full", full, 0);
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: single result
    push(32'h400, 1'b1, 1'b0);
    chk("t1_valid", fb_valid, 1);
    chk("t1_pc", fb_pc, 32'h400);
    chk("t1_pred", fb_pred, 1);
    chk("t1_out", fb_out, 0);
    chk("t1_mis", mispred_cnt, 1);
    chk("t1_bcnt", branch_cnt, 1);
    chk("t1_occ", occ, 1);
    fb_ready = 1'b1;
    tick();
    fb_ready = 1'b0;
    chk("t1_drained", fb_valid, 0);
    fb_ready = 1'b1;
    tick();
    fb_ready = 1'b0;
    chk("underflow_occ", occ, 0);

    // 2: backpressure
    do_reset();
    exp_mis = 0;
    for (int i = 1; i <= 5; i++) begin
      push(32'h100 * i, i[0], 1'b0);
      if (i[0]) exp_mis++;
      if (i == 4) begin
        chk("t2_full4", full, 1);
        chk("t2_occ4", occ, 4);
        chk("t2_drop4", drop_cnt, 0);
      end
    end
    chk("t2_drop", drop_cnt, 1);
    chk("t2_bcnt", branch_cnt, 5);
    chk("t2_mis", mispred_cnt, exp_mis);
    chk("t2_head", fb_pc, 32'h100);
    chk("t2_hpred", fb_pred, 1);

    // 3: full with simultaneous push and pop
    fb_ready = 1'b1;
    push(32'hABC, 1'b0, 1'b0);
    chk("t3_occ", occ, 4);
    chk("t3_full", full, 1);
    chk("t3_drop", drop_cnt, 1);
    exp_pc[0] = 32'h200;
    exp_pc[1] = 32'h300;
    exp_pc[2] = 32'h400;
    exp_pc[3] = 32'hABC;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_order%0d", i), fb_pc, exp_pc[i]);
      tick();
    end
    fb_ready = 1'b0;
    chk("t3_empty", fb_valid, 0);

    // 4: wrap-around on DEPTH=3
    r3  = 1'b1;
    rcv = 0;
    for (int i = 0; i < 14; i++) begin
      v3  = (i < 10);
      pc3 = 32'h1000 + i;
      p3  = 1'b0;
      o3  = 1'b1;
      tick();
      chk("t4_occ_le1", occ3 <= 2'd1, 1);
      if (fv3) begin
        chk($sformatf("t4_pc%0d", rcv), fpc3, 32'h1000 + rcv);
        rcv++;
      end
    end
    v3 = 1'b0;
    chk("t4_count", rcv, 10);
    chk("t4_mis", mc3, 10);

    // 5: async reset mid-operation
    do_reset();
    push(32'h10, 1'b1, 1'b0);
    push(32'h20, 1'b0, 1'b0);
    push(32'h30, 1'b1, 1'b1);
    chk("t5_occ3", occ, 3);
    rst = 1'b1;
    #1;
    chk("t5_valid", fb_valid, 0);
    chk("t5_occ", occ, 0);
    chk("t5_bcnt", branch_cnt, 0);
    chk("t5_mis", mispred_cnt, 0);
    chk("t5_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    push(32'h400, 1'b1, 1'b0);
    chk("t5_pc", fb_pc, 32'h400);
    chk("t5_occ1", occ, 1);
    chk("t5_bcnt1", branch_cnt, 1);
    chk("t5_mis1", mispred_cnt, 1);

    // 6: drop counter saturation
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h500 + i, 1'b0, 1'b0);
    res_valid = 1'b1;
    res_pc    = 32'hDEAD;
    for (int i = 0; i < 65534; i++) tick();
    chk("t6_fffe", drop_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    res_valid = 1'b0;
    chk("t6_sat", drop_cnt, 16'hFFFF);
    chk("t6_bcnt", branch_cnt, 4 + 65534 + 3);
    chk("t6_head", fb_pc, 32'h500);
    chk("t6_occ", occ, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
